// File: rtl/plru_pkg.sv
// Shared types for the tree-PLRU set controller.
// Operation codes, FSM states and the tree-width helper.
package plru_pkg;

  typedef enum logic [1:0] {
    OP_TOUCH  = 2'd0,
    OP_VICTIM = 2'd1,
    OP_PEEK   = 2'd2,
    OP_INVAL  = 2'd3
  } plru_op_t;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_COMMIT = 3'd3,
    ST_RESP   = 3'd4
  } plru_state_t;

  function automatic int tree_width(input int assoc);
    return assoc - 1;
  endfunction

endpackage

// File: rtl/plru_tree_next.sv
// Combinational next-row logic for one PLRU tree row.
// Victim walk plus MRU/LRU path marking.
module plru_tree_next
  import plru_pkg::*;
#(
  parameter int ASSOC = 8,
  localparam int TW = tree_width(ASSOC),
  localparam int LV = $clog2(ASSOC)
) (
  input  logic [TW-1:0] row,
  input  plru_op_t      op,
  input  logic [LV-1:0] way,
  output logic [TW-1:0] new_row,
  output logic [LV-1:0] result_way,
  output logic          write_en
);

  logic [LV-1:0] victim;
  logic [LV-1:0] target;
  logic          mru;
  logic          vb;
  logic          mb;
  int            vnode;
  int            mnode;

  // Walk away from the recorded direction at every level.
  always_comb begin
    victim = '0;
    vnode  = 0;
    vb     = 1'b0;
    for (int l = 0; l < LV; l++) begin
      vb = 1'b0;
      for (int i = 0; i < TW; i++) begin
        if (i == vnode) vb = ~row[i];
      end
      victim[LV-1-l] = vb;
      vnode = 2 * vnode + (vb ? 2 : 1);
    end
  end

  always_comb begin
    target = (op == OP_VICTIM) ? victim : way;
    mru    = (op != OP_INVAL);
  end

  // Only nodes on the path to target are rewritten.
  always_comb begin
    new_row = row;
    mnode   = 0;
    mb      = 1'b0;
    for (int l = 0; l < LV; l++) begin
      mb = target[LV-1-l];
      for (int i = 0; i < TW; i++) begin
        if (i == mnode) new_row[i] = mru ? mb : ~mb;
      end
      mnode = 2 * mnode + (mb ? 2 : 1);
    end
  end

  always_comb begin
    write_en   = (op != OP_PEEK);
    result_way = way;
    unique case (op)
      OP_VICTIM: result_way = victim;
      OP_PEEK:   result_way = victim;
      default:   result_way = way;
    endcase
  end

endmodule

// File: rtl/plru_set_controller.sv
// Tree-PLRU state owner: one read-modify-write request at a time.
// Optional PLRU_STATS_EN adds hit_count/fill_count op counters.
module plru_set_controller
  import plru_pkg::*;
#(
  parameter int ASSOC    = 8,
  parameter int NUM_SETS = 16,
  localparam int TW = tree_width(ASSOC),
  localparam int WW = $clog2(ASSOC),
  localparam int SW = $clog2(NUM_SETS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [SW-1:0] req_set,
  input  logic [WW-1:0] req_way,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [WW-1:0] rsp_way
`ifdef PLRU_STATS_EN
  ,
  output logic [31:0]   hit_count,
  output logic [31:0]   fill_count
`endif
);

  plru_state_t   state;
  plru_op_t      op_q;
  logic [SW-1:0] set_q;
  logic [WW-1:0] way_q;
  logic [TW-1:0] row_q;
  logic [SW-1:0] init_ptr;

  logic [TW-1:0] tree_mem [NUM_SETS];

  logic          mem_we;
  logic [SW-1:0] mem_addr;
  logic [TW-1:0] mem_wdata;

  logic [TW-1:0] new_row;
  logic [WW-1:0] result_way;
  logic          write_en;

  plru_tree_next #(
    .ASSOC(ASSOC)
  ) u_next (
    .row       (row_q),
    .op        (op_q),
    .way       (way_q),
    .new_row   (new_row),
    .result_way(result_way),
    .write_en  (write_en)
  );

  // INIT sweep and COMMIT share the single write port.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = set_q;
    mem_wdata = new_row;
    if (state == ST_INIT) begin
      mem_we    = 1'b1;
      mem_addr  = init_ptr;
      mem_wdata = '0;
    end else if (state == ST_COMMIT) begin
      mem_we = write_en;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) tree_mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_INIT;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_way    <= '0;
      op_q       <= OP_TOUCH;
      set_q      <= '0;
      way_q      <= '0;
      row_q      <= '0;
      init_ptr   <= '0;
`ifdef PLRU_STATS_EN
      hit_count  <= '0;
      fill_count <= '0;
`endif
    end else begin
      unique case (state)
        ST_INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == SW'(NUM_SETS - 1)) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_valid) begin
            op_q      <= plru_op_t'(req_op);
            set_q     <= req_set;
            way_q     <= req_way;
            req_ready <= 1'b0;
            state     <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          row_q <= tree_mem[set_q];
          state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          rsp_way   <= result_way;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
`ifdef PLRU_STATS_EN
          if (op_q == OP_TOUCH)  hit_count  <= hit_count + 32'd1;
          if (op_q == OP_VICTIM) fill_count <= fill_count + 32'd1;
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
